// File: rtl/lsu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bridge
// Brief    : Single-outstanding CPU load/store to memory bridge with
//            alignment checking and a bounded wait (timeout) on mem_busy.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_we,
    output logic        mem_re,
    output logic [1:0]  mem_size,
    output logic        mem_signed,
    input  logic [31:0] mem_read_data,
    input  logic        mem_busy
);

    localparam int                 c_CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [1:0]         c_ERR_OK    = 2'b00;
    localparam logic [1:0]         c_ERR_ALIGN = 2'b01;
    localparam logic [1:0]         c_ERR_TMO   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_rdata;
    logic [1:0]           r_resp_err;
    logic [31:0]          r_mem_address;
    logic [31:0]          r_mem_write_data;
    logic                 r_mem_we;
    logic                 r_mem_re;
    logic [1:0]           r_mem_size;
    logic                 r_mem_signed;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_misaligned;

    // Byte accesses can never be misaligned; size 11 is always rejected.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= 32'd0;
            r_resp_err       <= c_ERR_OK;
            r_mem_address    <= 32'd0;
            r_mem_write_data <= 32'd0;
            r_mem_we         <= 1'b0;
            r_mem_re         <= 1'b0;
            r_mem_size       <= 2'b00;
            r_mem_signed     <= 1'b0;
            r_cnt            <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (req_valid) begin
                        r_mem_address    <= req_addr;
                        r_mem_write_data <= req_wdata;
                        r_mem_size       <= req_size;
                        r_mem_signed     <= req_signed;
                        r_req_ready      <= 1'b0;
                        if (w_misaligned) begin
                            // Rejected requests never reach the memory side.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= c_ERR_ALIGN;
                            r_resp_rdata <= 32'd0;
                        end else begin
                            r_state  <= S_ACCESS;
                            r_cnt    <= '0;
                            r_mem_we <= req_we;
                            r_mem_re <= ~req_we;
                        end
                    end
                end

                S_ACCESS: begin
                    // Completion is tested first so it wins on the last allowed cycle.
                    if (!mem_busy) begin
                        r_state      <= S_RESP;
                        r_mem_we     <= 1'b0;
                        r_mem_re     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= c_ERR_OK;
                        r_resp_rdata <= r_mem_we ? 32'd0 : mem_read_data;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state      <= S_RESP;
                        r_mem_we     <= 1'b0;
                        r_mem_re     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= c_ERR_TMO;
                        r_resp_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_mem_we     <= 1'b0;
                    r_mem_re     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign resp_err       = r_resp_err;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign mem_we         = r_mem_we;
    assign mem_re         = r_mem_re;
    assign mem_size       = r_mem_size;
    assign mem_signed     = r_mem_signed;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bridge
// Brief    : Scoreboard bench for lsu_bridge: directed scenarios plus random
//            requests checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bridge;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_read_data = 32'd0;
    logic        mem_busy = 1'b0;

    always #5 clk = ~clk;

    lsu_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .mem_size       (mem_size),
        .mem_signed     (mem_signed),
        .mem_read_data  (mem_read_data),
        .mem_busy       (mem_busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          acc;
        int          t_acc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          cur_busy = 0;
    logic [31:0] cur_rdata = 32'd0;
    int          mem_cnt = 0;
    int          acc_n = 0;
    logic [31:0] last_rdata = 32'd0;
    logic [1:0]  last_err = 2'b00;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    endtask

    // Memory responder: holds busy for cur_busy cycles of each access.
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            mem_busy      = (mem_cnt < cur_busy);
            mem_read_data = mem_busy ? $urandom : cur_rdata;
            mem_cnt++;
        end else begin
            mem_cnt       = 0;
            mem_busy      = 1'($urandom_range(0, 1));
            mem_read_data = $urandom;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            acc_n      = 0;
            last_rdata = 32'd0;
            last_err   = 2'b00;
        end else begin
            chk("req_ready_state", 32'(req_ready), 32'(!(mem_we || mem_re || resp_valid)));
            if (mem_we || mem_re) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_access", 32'(mem_we || mem_re), 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_re", 32'(mem_re), 32'(!e.we));
                    chk("mem_address", mem_address, e.addr);
                    chk("mem_write_data", mem_write_data, e.wdata);
                    chk("mem_size", 32'(mem_size), 32'(e.size));
                    chk("mem_signed", 32'(mem_signed), 32'(e.sgn));
                    acc_n++;
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_latency", 32'(cyc - e.t_acc), 32'(e.lat));
                    chk("access_cycles", 32'(acc_n), 32'(e.acc));
                    last_rdata = e.rdata;
                    last_err   = e.err;
                end
                acc_n = 0;
            end else begin
                chk("rdata_hold", resp_rdata, last_rdata);
                chk("err_hold", 32'(resp_err), 32'(last_err));
            end
        end
    end

    // Reference model: outcome of a request from its fields and the busy length.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn, input int busy_n,
                         input logic [31:0] rdata, input bit keep, output int t_acc);
        exp_t e;
        bit   mis;
        bit   got;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        req_valid  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 * T + 64 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_wait: req_ready stayed 0 past the wait limit, expected 1");
            summary();
            $finish;
        end
        mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        e.we = we; e.addr = addr; e.wdata = wdata; e.size = size; e.sgn = sgn;
        if (mis) begin
            e.err = 2'b01; e.rdata = 32'd0; e.lat = 0; e.acc = 0;
        end else if (busy_n >= T) begin
            e.err = 2'b10; e.rdata = 32'd0; e.lat = T; e.acc = T;
        end else begin
            e.err = 2'b00; e.rdata = we ? 32'd0 : rdata; e.lat = busy_n + 1; e.acc = busy_n + 1;
        end
        e.t_acc   = cyc + 1;
        t_acc     = e.t_acc;
        cur_busy  = busy_n;
        cur_rdata = rdata;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    initial begin
        int          a1, a2, a3, t, tr;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r, busy;
        bit          keep;

        #1 rst_n = 1'b0;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_size", 32'(mem_size), 32'd0);
        chk("rst_mem_signed", 32'(mem_signed), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 32'h0000_0010, 32'h0, 2'b10, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, t);
        issue(1'b1, 32'h0000_4004, 32'h1234_5678, 2'b10, 1'b0, 5, 32'hA5A5_5A5A, 1'b0, t);
        issue(1'b0, 32'h0000_4001, 32'h0, 2'b01, 1'b1, 0, 32'h1111_1111, 1'b0, t);
        issue(1'b1, 32'h0000_4000, 32'h9999_0000, 2'b11, 1'b0, 0, 32'h2222_2222, 1'b0, t);
        issue(1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 1000, 32'h3333_3333, 1'b0, t);
        issue(1'b0, 32'h0000_0104, 32'h0, 2'b10, 1'b0, T - 1, 32'h4444_4444, 1'b0, t);
        issue(1'b0, 32'h0000_0203, 32'h0, 2'b00, 1'b1, 2, 32'h0000_0080, 1'b0, t);

        issue(1'b0, 32'h0000_0300, 32'h0, 2'b10, 1'b0, 0, 32'h0101_0101, 1'b1, a1);
        issue(1'b1, 32'h0000_0302, 32'hBEEF_CAFE, 2'b01, 1'b0, 0, 32'h0202_0202, 1'b1, a2);
        issue(1'b0, 32'h0000_0308, 32'h0, 2'b10, 1'b1, 0, 32'h0303_0303, 1'b0, a3);
        chk("b2b_spacing_1", 32'(a2 - a1), 32'd3);
        chk("b2b_spacing_2", 32'(a3 - a2), 32'd3);

        // Reset while the memory is stalling a read.
        issue(1'b0, 32'h0000_0020, 32'h0, 2'b10, 1'b0, 1000, 32'h5555_AAAA, 1'b0, t);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_mem_re", 32'(mem_re), 32'd0);
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid_req_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tr = cyc;
        issue(1'b0, 32'h0000_0024, 32'h0, 2'b10, 1'b0, 0, 32'hCAFE_F00D, 1'b0, t);
        chk("accept_after_reset", 32'(t), 32'(tr + 1));

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sz = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            busy = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
            keep = (n != 149) && ($urandom_range(0, 1) == 1);
            issue(we, ad, $urandom, sz, 1'($urandom_range(0, 1)), busy, $urandom, keep, t);
            if (!keep) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        summary();
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_bridge.md
LSU_BRIDGE -- requirements
Module: lsu_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024 (minimum 2): maximum number of ACCESS cycles before a transfer is aborted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid (input, 1), req_ready (output, 1): CPU request handshake.
REQ-005 SHALL have CPU request inputs req_we (1, 1=store), req_addr (32), req_wdata (32), req_size (2: 00 byte, 01 half, 10 word, 11 illegal) and req_signed (1).
REQ-006 SHALL have CPU response outputs resp_valid (1), resp_rdata (32) and resp_err (2: 00 ok, 01 misaligned/illegal size, 10 timeout).
REQ-007 SHALL have memory-side outputs mem_address (32), mem_write_data (32), mem_we (1), mem_re (1), mem_size (2) and mem_signed (1).
REQ-008 SHALL have memory-side inputs mem_read_data (32) and mem_busy (1; combinational, valid only while mem_we or mem_re is high).

Function
REQ-009 SHALL implement states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL, in IDLE with req_valid=1, register addr, wdata, we, size and signed into the mem_* output registers in the same cycle.
REQ-011 SHALL flag misalignment when size=01 and addr[0]=1, when size=10 and addr[1:0]!=0, or when size=11; byte access is never misaligned.
REQ-012 SHALL, on a misaligned accept, go IDLE->RESP with resp_err=01 and resp_rdata=0, never asserting mem_we or mem_re.
REQ-013 SHALL, on an aligned accept, go IDLE->ACCESS and clear the timeout counter.
REQ-014 SHALL, in ACCESS, drive mem_we=captured we and mem_re=~captured we; both are 0 in every other state.
REQ-015 SHALL keep mem_address, mem_write_data, mem_size and mem_signed stable for the whole ACCESS residency.
REQ-016 SHALL treat an ACCESS cycle with mem_busy=0 as the completion cycle: for reads, capture mem_read_data into resp_rdata (0 for writes), set resp_err=00, and go to RESP.
REQ-017 SHALL increment the counter on each ACCESS cycle with mem_busy=1 (counter width clog2(TIMEOUT_CYCLES)+1, no wrap).
REQ-018 SHALL, when the counter reaches TIMEOUT_CYCLES-1 with mem_busy still 1, go to RESP with resp_err=10 and resp_rdata=0, so mem_we/mem_re are high for at most TIMEOUT_CYCLES cycles.
REQ-019 SHALL give completion priority over timeout when mem_busy falls on the final allowed cycle.
REQ-020 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-021 SHALL give zero-wait latency: accept at edge N, mem_re/mem_we high during cycle N+1, resp_valid during cycle N+2.
REQ-022 SHALL give busy-wait latency: each busy cycle adds one cycle; resp_valid rises in the cycle after the first mem_busy=0 cycle of ACCESS.
REQ-023 SHALL accept a held req_valid back-to-back: the next request is accepted in the IDLE cycle following RESP (no more than one request per 3 cycles).
REQ-024 SHALL hold resp_rdata and resp_err stable after RESP until the next response.
REQ-025 SHALL pass req_wdata unmodified; byte lane handling and sign extension are done downstream.

Reset
REQ-026 SHALL, while rst_n=0 (asynchronously), force state IDLE, mem_we=0, mem_re=0, resp_valid=0, req_ready=1, and set all registered data outputs, resp_err and the counter to 0.
REQ-027 SHALL, on reset during ACCESS, drop mem_we/mem_re immediately, produce no response, and accept the next request in the first cycle after rst_n rises.

Verification
REQ-028 SHALL cover peripheral read: word at 0x00000010, mem_busy=0, mem_read_data=0xDEADBEEF -> mem_re high exactly 1 cycle, resp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=00.
REQ-029 SHALL cover RAM write: word at 0x00004004, data 0x12345678, mem_busy=1 for 5 cycles -> mem_we high 6 cycles with address/data stable, resp_valid the next cycle, err=00.
REQ-030 SHALL cover misalignment: half at 0x00004001 and size=11 at 0x00004000 -> no mem_we/mem_re, resp_valid 1 cycle after accept, err=01, rdata=0.
REQ-031 SHALL cover timeout: TIMEOUT_CYCLES=16, mem_busy stuck at 1 on a read -> mem_re high exactly 16 cycles, then resp err=10, rdata=0, req_ready=1 the following cycle.
REQ-032 SHALL cover reset mid-ACCESS: rst_n low while busy -> mem_re falls without waiting for a clock edge, no resp_valid, a new request is accepted the first cycle after release.
REQ-033 SHALL cover back-to-back: req_valid held high for 3 requests, zero-wait -> accepts every 3rd cycle, 3 single-cycle resp_valid pulses, req_ready low in ACCESS/RESP.
